// File: rtl/riscv_fetch_pkg.sv
// Shared types for the instruction fetch front end.
//   NOP_INSTR     : addi x0,x0,0, presented when the queue is empty
//   fetch_state_t : outstanding-request tracker (idle / keep / discard)
//   fq_entry_t    : one queued instruction with the PC it was fetched from
package riscv_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    S_IDLE,  // nothing outstanding
    S_BUSY,  // one request outstanding, response will be queued
    S_DROP   // one request outstanding, response will be discarded
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched instructions.
//   clk, reset  : clock, synchronous active-high reset
//   push, wdata : enqueue wdata (accepted when not full, or full with a pop)
//   pop         : dequeue the head (ignored when empty)
//   flush       : empty the FIFO; wins over push and pop
//   full, almost_full, empty : occupancy flags (almost_full = DEPTH-1 entries)
//   head        : current head entry (undefined when empty)
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  fq_entry_t wdata,
  input  logic      pop,
  input  logic      flush,
  output logic      full,
  output logic      almost_full,
  output logic      empty,
  output fq_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  fq_entry_t         mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       count;
  logic              do_push, do_pop;

  assign empty       = (count == '0);
  assign full        = (count == (AW+1)'(DEPTH));
  assign almost_full = (count == (AW+1)'(DEPTH - 1));
  assign do_pop      = pop && !empty;
  assign do_push     = push && (!full || do_pop);
  assign head        = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues one word fetch at a time to a
// variable-latency instruction memory and queues responses with their PCs.
//   clk, reset              : clock, synchronous active-high reset
//   imem_req, imem_addr     : single-cycle fetch request (always accepted)
//   imem_ack, imem_rdata    : response strobe and instruction word
//   en_f                    : consumer takes the head entry this cycle
//   redirect, redirect_pc   : taken control transfer; flushes the queue
//   valid_f, instr_f, pc_f, pcplus4_f : head entry (NOP/0/0 when empty)
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        en_f,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        valid_f,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] pcplus4_f
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  req_pc;    // address of the outstanding request
  fq_entry_t    head, push_entry;
  logic         full, almost_full, empty;
  logic         busy_ack, space, push, pop;

  assign busy_ack = imem_ack && (state == S_BUSY);

  // Room for one more response, counting the one landing this cycle.
  // Pop is left out on purpose so en_f never reaches imem_req.
  assign space = !full && !(almost_full && busy_ack);

  assign imem_req  = !reset && !redirect && space &&
                     ((state == S_IDLE) || imem_ack);
  assign imem_addr = fetch_pc;

  assign push       = busy_ack && !redirect;
  assign pop        = !empty && en_f && !redirect;
  assign push_entry = '{pc: req_pc, instr: imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .wdata       (push_entry),
    .pop         (pop),
    .flush       (redirect),
    .full        (full),
    .almost_full (almost_full),
    .empty       (empty),
    .head        (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~32'h3;
      // A response landing now is already dropped, so nothing is left
      // outstanding; otherwise an in-flight request becomes a discard.
      if (imem_ack)               state <= S_IDLE;
      else if (state == S_BUSY)   state <= S_DROP;
    end else if (imem_req) begin
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + 32'd4;
      state    <= S_BUSY;
    end else if (imem_ack) begin
      state <= S_IDLE;
    end
  end

  assign valid_f   = !empty;
  assign instr_f   = valid_f ? head.instr : NOP_INSTR;
  assign pc_f      = valid_f ? head.pc : 32'h0;
  assign pcplus4_f = valid_f ? head.pc + 32'd4 : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h00000000;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        en_f = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        valid_f;
  logic [31:0] instr_f, pc_f, pcplus4_f;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .en_f(en_f),
    .redirect(redirect), .redirect_pc(redirect_pc), .valid_f(valid_f),
    .instr_f(instr_f), .pc_f(pc_f), .pcplus4_f(pcplus4_f)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  // memory environment
  int          lat = 1;
  int          cyc = 0;
  bit          mem_busy = 0;
  int          mem_due = 0;
  logic [31:0] mem_addr = 0;

  // reference model: queue of PCs plus outstanding-request bookkeeping
  logic [31:0] mq[$];
  logic [31:0] mpc = RESET_PC;
  logic [31:0] mreq_pc = RESET_PC;
  int          mst = 0;  // 0 nothing outstanding, 1 keep, 2 discard

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5AA5A5;
  endfunction

  function automatic bit m_req();
    int occ;
    occ = mq.size() + ((imem_ack && mst == 1) ? 1 : 0);
    return !reset && !redirect && (occ < DEPTH) && (mst == 0 || imem_ack);
  endfunction

  task automatic drive(input bit rst, input bit en, input bit rd, input logic [31:0] rpc);
    reset = rst; en_f = en; redirect = rd; redirect_pc = rpc;
    imem_ack   = mem_busy && (cyc == mem_due);
    imem_rdata = imem_ack ? mem_word(mem_addr) : 32'hDEADBEEF;
    #1;
  endtask

  task automatic advance();
    bit req_m, ack;
    req_m = m_req();
    ack = imem_ack;
    if (reset) mem_busy = 0;
    else begin
      if (ack) mem_busy = 0;
      if (imem_req) begin mem_busy = 1; mem_due = cyc + lat; mem_addr = imem_addr; end
    end
    if (reset) begin
      mq.delete(); mpc = RESET_PC; mst = 0;
    end else if (redirect) begin
      mq.delete(); mpc = redirect_pc & ~32'h3;
      if (ack) mst = 0; else if (mst == 1) mst = 2;
    end else begin
      if (mq.size() > 0 && en_f) void'(mq.pop_front());
      if (ack && mst == 1) mq.push_back(mreq_pc);
      if (req_m) begin mreq_pc = mpc; mpc = mpc + 32'd4; mst = 1; end
      else if (ack) mst = 0;
    end
    cyc++;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic do_reset(input int l);
    lat = l;
    repeat (2) begin drive(1, 0, 0, 0); advance(); end
  endtask

  task automatic test_reset();
    lat = 1;
    drive(1, 0, 0, 0);
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL reset_req0: got %b want 0", imem_req); else pass_cnt++;
    advance();
    drive(1, 0, 0, 0);
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else pass_cnt++;
    total_cnt++; if (valid_f !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_f); else pass_cnt++;
    total_cnt++; if (instr_f !== NOP) $display("FAIL reset_instr: got %h want %h", instr_f, NOP); else pass_cnt++;
    total_cnt++; if (pc_f !== 32'h0) $display("FAIL reset_pc: got %h want 0", pc_f); else pass_cnt++;
    total_cnt++; if (pcplus4_f !== 32'h0) $display("FAIL reset_pcplus4: got %h want 0", pcplus4_f); else pass_cnt++;
    advance();
  endtask

  task automatic test_stream();
    logic [31:0] ep;
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 0, 0);
      total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*i))
        $display("FAIL stream_req[%0d]: got %b/%h want 1/%h", i, imem_req, imem_addr, 32'(4*i)); else pass_cnt++;
      if (i >= 2) begin
        ep = 32'(4*(i-2));
        total_cnt++; if (valid_f !== 1'b1 || pc_f !== ep || instr_f !== mem_word(ep) || pcplus4_f !== ep + 4)
          $display("FAIL stream_head[%0d]: got v=%b pc=%h in=%h p4=%h want pc=%h", i, valid_f, pc_f, instr_f, pcplus4_f, ep);
        else pass_cnt++;
      end else begin
        total_cnt++; if (valid_f !== 1'b0) $display("FAIL stream_early_valid[%0d]: got %b want 0", i, valid_f); else pass_cnt++;
      end
      advance();
    end
  endtask

  task automatic test_full();
    int nreq = 0;
    logic [31:0] exp = 0;
    bit got_first = 0;
    logic [31:0] first_req = 0;
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0);
      if (imem_req) nreq++;
      advance();
    end
    drive(0, 0, 0, 0);
    total_cnt++; if (nreq != DEPTH) $display("FAIL full_nreq: got %0d want %0d", nreq, DEPTH); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL full_req: got %b want 0", imem_req); else pass_cnt++;
    total_cnt++; if (valid_f !== 1'b1 || pc_f !== 32'h0) $display("FAIL full_head: got %b/%h want 1/0", valid_f, pc_f); else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 0, 0);
      if (imem_req && !got_first) begin got_first = 1; first_req = imem_addr; end
      total_cnt++; if (valid_f !== 1'b1 || pc_f !== exp)
        $display("FAIL drain_pc[%0d]: got %b/%h want 1/%h", i, valid_f, pc_f, exp); else pass_cnt++;
      exp = exp + 4;
      advance();
    end
    total_cnt++; if (!got_first || first_req !== 32'h10)
      $display("FAIL resume_addr: got %b/%h want 1/00000010", got_first, first_req); else pass_cnt++;
  endtask

  task automatic test_redirect_l3();
    bit got_req = 0, got_v = 0, saw8 = 0;
    logic [31:0] first_req = 0, first_v = 0;
    do_reset(3);
    for (int i = 0; i < 7; i++) begin drive(0, 1, 0, 0); advance(); end
    drive(0, 1, 1, 32'h100);
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL l3_redir_req: got %b want 0", imem_req); else pass_cnt++;
    advance();
    drive(0, 1, 0, 0);
    total_cnt++; if (valid_f !== 1'b0) $display("FAIL l3_valid_after: got %b want 0", valid_f); else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) drive(0, 1, 0, 0);
      if (imem_req && !got_req) begin got_req = 1; first_req = imem_addr; end
      if (valid_f && !got_v) begin got_v = 1; first_v = pc_f; end
      if (valid_f && pc_f == 32'h8) saw8 = 1;
      advance();
    end
    total_cnt++; if (!got_req || first_req !== 32'h100) $display("FAIL l3_first_req: got %b/%h want 1/00000100", got_req, first_req); else pass_cnt++;
    total_cnt++; if (!got_v || first_v !== 32'h100) $display("FAIL l3_first_valid: got %b/%h want 1/00000100", got_v, first_v); else pass_cnt++;
    total_cnt++; if (saw8) $display("FAIL l3_stale: got pc 00000008 want discarded"); else pass_cnt++;
  endtask

  task automatic test_redirect_ack();
    do_reset(1);
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 0); advance(); end
    drive(0, 1, 1, 32'h43);
    total_cnt++; if (imem_ack !== 1'b1 || valid_f !== 1'b1) $display("FAIL rack_setup: got ack=%b v=%b want 1/1", imem_ack, valid_f); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL rack_req: got %b want 0", imem_req); else pass_cnt++;
    advance();
    drive(0, 1, 0, 0);
    total_cnt++; if (valid_f !== 1'b0) $display("FAIL rack_valid: got %b want 0", valid_f); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) $display("FAIL rack_next: got %b/%h want 1/00000040", imem_req, imem_addr); else pass_cnt++;
    advance();
    drive(0, 1, 0, 0);
    total_cnt++; if (valid_f !== 1'b0) $display("FAIL rack_gap: got %b want 0", valid_f); else pass_cnt++;
    advance();
    drive(0, 1, 0, 0);
    total_cnt++; if (valid_f !== 1'b1 || pc_f !== 32'h40) $display("FAIL rack_head: got %b/%h want 1/00000040", valid_f, pc_f); else pass_cnt++;
    advance();
  endtask

  task automatic test_wrap();
    do_reset(1);
    drive(0, 1, 1, 32'hFFFFFFFE); advance();
    drive(0, 1, 0, 0);
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFFFFFC) $display("FAIL wrap_req0: got %b/%h want 1/fffffffc", imem_req, imem_addr); else pass_cnt++;
    advance();
    drive(0, 1, 0, 0);
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL wrap_req1: got %b/%h want 1/00000000", imem_req, imem_addr); else pass_cnt++;
    advance();
    drive(0, 1, 0, 0);
    total_cnt++; if (valid_f !== 1'b1 || pc_f !== 32'hFFFFFFFC || pcplus4_f !== 32'h0 || instr_f !== mem_word(32'hFFFFFFFC))
      $display("FAIL wrap_head: got %b/%h/%h/%h want 1/fffffffc/00000000", valid_f, pc_f, pcplus4_f, instr_f); else pass_cnt++;
    advance();
    drive(0, 1, 0, 0);
    total_cnt++; if (valid_f !== 1'b1 || pc_f !== 32'h0 || pcplus4_f !== 32'h4) $display("FAIL wrap_next: got %b/%h/%h want 1/0/4", valid_f, pc_f, pcplus4_f); else pass_cnt++;
    advance();
  endtask

  task automatic test_reset_mid();
    do_reset(2);
    for (int i = 0; i < 7; i++) begin drive(0, 0, 0, 0); advance(); end
    drive(1, 0, 0, 0);
    total_cnt++; if (valid_f !== 1'b1 || pc_f !== 32'h0) $display("FAIL rmid_pre: got %b/%h want 1/0", valid_f, pc_f); else pass_cnt++;
    total_cnt++; if (imem_req !== 1'b0) $display("FAIL rmid_req: got %b want 0", imem_req); else pass_cnt++;
    advance();
    drive(1, 0, 0, 0);
    total_cnt++; if (valid_f !== 1'b0 || instr_f !== NOP || imem_req !== 1'b0)
      $display("FAIL rmid_post: got v=%b in=%h req=%b want 0/00000013/0", valid_f, instr_f, imem_req); else pass_cnt++;
    advance();
    drive(0, 1, 0, 0);
    total_cnt++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) $display("FAIL rmid_first: got %b/%h want 1/%h", imem_req, imem_addr, RESET_PC); else pass_cnt++;
    advance();
  endtask

  task automatic test_random();
    bit rst, en, rd;
    logic [31:0] rpc, hp;
    for (int seg = 0; seg < 4; seg++) begin
      do_reset(1 + int'($urandom_range(0, 3)));
      for (int i = 0; i < 150; i++) begin
        rst = ($urandom_range(0, 99) == 0);
        en  = ($urandom_range(0, 3) != 0);
        rd  = ($urandom_range(0, 11) == 0);
        rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
        drive(rst, en, rd, rpc);
        total_cnt++; if (imem_req !== m_req() || (m_req() && imem_addr !== mpc))
          $display("FAIL rnd_req[%0d.%0d]: got %b/%h want %b/%h", seg, i, imem_req, imem_addr, m_req(), mpc); else pass_cnt++;
        if (mq.size() > 0) begin
          hp = mq[0];
          total_cnt++; if (valid_f !== 1'b1 || pc_f !== hp || instr_f !== mem_word(hp) || pcplus4_f !== hp + 32'd4)
            $display("FAIL rnd_head[%0d.%0d]: got %b/%h/%h/%h want pc %h", seg, i, valid_f, pc_f, instr_f, pcplus4_f, hp); else pass_cnt++;
        end else begin
          total_cnt++; if (valid_f !== 1'b0 || instr_f !== NOP || pc_f !== 32'h0 || pcplus4_f !== 32'h0)
            $display("FAIL rnd_empty[%0d.%0d]: got %b/%h/%h/%h want 0/nop/0/0", seg, i, valid_f, instr_f, pc_f, pcplus4_f); else pass_cnt++;
        end
        advance();
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full();
    test_redirect_l3();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end for the 5-stage RISC-V pipeline. It issues word fetches to a variable-latency instruction memory and buffers the returned instructions, with their PCs, in a small FIFO. It presents the head entry to the fetch/decode pipeline register. It replaces the direct PC → instr_mem path: a stall holds the head, and a taken branch or jump flushes the queue and discards in-flight responses.

## Interface

Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- RESET_PC, 32'h00000000: first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  single-cycle fetch request; the memory always accepts it.
- imem_addr  out  32  fetch address, word aligned; valid while imem_req=1.
- imem_ack  in  1  response strobe, at least 1 cycle after its request.
- imem_rdata  in  32  instruction word; valid while imem_ack=1.
- en_f  in  1  the consumer accepts the head entry this cycle (corresponds to en_fd).
- redirect  in  1  taken control transfer (pcsrc_e).
- redirect_pc  in  32  new fetch address (pctarget_e); bits [1:0] are forced to 0.
- valid_f  out  1  the head entry is valid.
- instr_f  out  32  head instruction; 32'h00000013 (NOP) when valid_f=0.
- pc_f  out  32  head PC; 0 when valid_f=0.
- pcplus4_f  out  32  pc_f + 4; 0 when valid_f=0.

## Operation

- State: fetch_pc (32), FIFO count (0..DEPTH), FSM {S_IDLE, S_BUSY, S_DROP}.
  - S_IDLE: nothing outstanding.
  - S_BUSY: one request outstanding; its response will be kept.
  - S_DROP: one request outstanding; its response will be discarded.
- Only one request is outstanding at a time.
- space = (count + (imem_ack && state==S_BUSY)) < DEPTH. Pop is deliberately excluded, so there is no en_f → imem_req path.
- imem_req = !reset && !redirect && space && (state==S_IDLE || imem_ack).
- imem_addr = fetch_pc.
- On each issued request, fetch_pc += 4 (modulo 2^32 wrap). The FSM moves to S_BUSY.
- imem_ack in S_BUSY: push {fetch address, imem_rdata}. The FSM moves to S_IDLE unless a new request issues in the same cycle, in which case it stays in S_BUSY.
- imem_ack in S_DROP: the data is discarded. The FSM moves to S_IDLE, or to S_BUSY if a request issues in the same cycle.
- imem_ack in S_IDLE: ignored. Verification flags this as an error.
- Pop: valid_f && en_f && !redirect removes the head entry.
- Push and pop may occur in the same cycle; count is then unchanged.
- Redirect, which has the highest priority:
  - count ← 0 and fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - S_BUSY → S_DROP. S_DROP stays S_DROP. S_IDLE stays S_IDLE.
  - An imem_ack arriving in the same cycle is dropped, and the FSM goes to S_IDLE.
  - No request is issued in the redirect cycle. The first fetch at the new PC issues in the next cycle if the FSM is in S_IDLE.
- Reset: count=0, fetch_pc=RESET_PC, state=S_IDLE. Outputs: imem_req=0, valid_f=0, instr_f=NOP, pc_f=0, pcplus4_f=0.
  - Reset mid-request puts the FSM in S_IDLE. A late ack after reset is ignored; the memory is reset with the core.

## Timing

- All outputs except imem_req are functions of registered state only. imem_req additionally depends combinationally on imem_ack and redirect.
- First request: the first cycle with reset=0, at address RESET_PC.
- Memory latency L=1 (ack in the cycle after the request):
  - Request in cycle n, push at the end of cycle n+1, valid_f=1 in cycle n+2.
  - Steady-state throughput is 1 instruction per cycle.
- Memory latency L>1: throughput is 1 instruction per L cycles.
- Redirect in cycle r: valid_f=0 in cycle r+1. The first new-path instruction is valid in cycle r+1+L+1 (L=1: cycle r+3), the same as a 2-cycle branch penalty plus one cycle.
- Full (count=DEPTH, no pop): no request is issued. Fetch resumes the cycle after a pop.
- Empty: valid_f=0 and NOP is presented; the control logic inserts a bubble.

## Structure

- Package riscv_fetch_pkg:
  - NOP_INSTR = 32'h00000013.
  - fetch_state_t enum {S_IDLE, S_BUSY, S_DROP}.
  - fq_entry_t struct {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo: synchronous FIFO of fq_entry_t with DEPTH entries.
  - Wrap-around read and write pointers of $clog2(DEPTH) bits, plus a count.
  - Ports: push, pop, flush, full, empty, head.
  - flush has priority over push and pop.
- fetch_queue contains the FSM, fetch_pc, request logic and output muxing (pcplus4_f adder, NOP substitution).

## Test plan

- Reset, L=1, en_f=1, memory holding instr = address: request at 0,4,8,… on consecutive cycles; valid_f rises 2 cycles after reset release; pc_f increments by 4 every cycle and pcplus4_f = pc_f+4.
- en_f=0 for 10 cycles, L=1: exactly DEPTH=4 entries fill, then imem_req stays 0; the head holds pc_f=0x0. After en_f=1, four pops occur and fetching resumes at 0x10 with no gap or duplicate.
- L=3, redirect to 0x100 while a request to 0x8 is outstanding: valid_f=0 the next cycle, the 0x8 response is discarded, the next request is 0x100, and the first valid pc_f is 0x100.
- Redirect in the same cycle as imem_ack and en_f: no push and no pop, count=0; the next cycle issues a request at redirect_pc.
- redirect_pc=0xFFFFFFFE: fetches 0xFFFFFFFC, then 0x00000000 (wrap); pcplus4_f for the head 0xFFFFFFFC is 0x0.
- Reset asserted with 3 entries queued and a request outstanding: the next cycle valid_f=0, instr_f=0x00000013 and imem_req=0. After release, the first request is at RESET_PC.
